uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side bundle for uart_rx: serial line in, acknowledge in, received byte and status out.
interface uart_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;

    modport master (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized RX line, with a byte-ready
// handshake, a frame error flag and an overrun flag.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    localparam int unsigned CNT_W    = 13;
    localparam int unsigned BIT_W    = 4;
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(7);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic             rx_meta, rx_s;
    logic [1:0]       sync_vld;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             rdy_q, rdy_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    // Two-flop synchronizer; sync_vld marks when rx_s reflects the real line rather than reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            sync_vld <= 2'b00;
        end else begin
            rx_meta  <= bus.RX;
            rx_s     <= rx_meta;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= 8'h00;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // A start is only accepted after the line has been seen high, so a line stuck low is not a frame.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q | (sync_vld[1] & rx_s);
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (bus.clr_rdy) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (armed_q && !rx_s) begin
                    state_d = START;
                    bit_d   = '0;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        // A completing byte beats a same-cycle acknowledge.
                        data_d = shift_q;
                        rdy_d  = 1'b1;
                        if (rdy_q && !bus.clr_rdy) begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rdy       = rdy_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule
